// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding,
// master indices and the legal range of the access-time parameter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MASTER_CPU = 1'b0;
   localparam logic MASTER_DMA = 1'b1;

   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = 4;

endpackage

// File: rtl/bus_arb_rr.sv
// Combinational 2-way round-robin chooser. A lone requester always wins;
// on a tie the master that was not granted last wins.
module bus_arb_rr
   import bus_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   // Pick the winner from the request vector and the last-granted pointer.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      gnt_valid = |req;
      gnt_idx   = MASTER_CPU;
      case (req)
         2'b01:   gnt_idx = MASTER_CPU;
         2'b10:   gnt_idx = MASTER_DMA;
         2'b11:   gnt_idx = ~last;
         default: gnt_idx = MASTER_CPU;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the CPU-side port of the address-decoding
// bus. Master 0 is the CPU load/store port, master 1 the loader/debug DMA.
// Each access holds address/data for WAIT_CYCLES cycles, strobes c_we only in
// the last of them, then pulses the owner's ack for one cycle.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] c_address,
   output logic          c_we,
   output logic [DW-1:0] c_wdata,
   input  logic [DW-1:0] c_rdata,
   output logic          gnt_id,
   output logic          bus_busy
);

   // Out-of-range access times are saturated into the supported 1..15 window.
   localparam int WAIT_EFF = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                             (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gnt_q, gnt_d;
   logic             last_q, last_d;
   logic             we_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;
   logic [DW-1:0]    rdata0_q, rdata1_q;
   logic             latch_en;
   logic             cap0, cap1;
   logic             rr_valid, rr_idx;

   bus_arb_rr u_rr (
      .req       ({m1_req, m0_req}),
      .last      (last_q),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   // Next-state, counter and pointer logic of the access FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      latch_en = 1'b0;
      cap0     = 1'b0;
      cap1     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rr_valid) begin
               latch_en = 1'b1;
               gnt_d    = rr_idx;
               cnt_d    = CNT_LOAD;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               last_d  = gnt_q;
               state_d = DONE;
               cap0    = !we_q && (gnt_q == MASTER_CPU);
               cap1    = !we_q && (gnt_q == MASTER_DMA);
            end
         end
         DONE: begin
            // Masters get this cycle to drop or replace req after the ack.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, counter, grant and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt_q   <= MASTER_CPU;
         last_q  <= MASTER_DMA;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   // Winner's command, sampled once at the grant edge and held for the access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: data registers are reset too, because rdata and c_* must read 0 after reset.
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (latch_en) begin
         we_q    <= (rr_idx == MASTER_DMA) ? m1_we    : m0_we;
         addr_q  <= (rr_idx == MASTER_DMA) ? m1_addr  : m0_addr;
         wdata_q <= (rr_idx == MASTER_DMA) ? m1_wdata : m0_wdata;
      end
   end

   // Per-master read data, captured on the last BUSY cycle of a read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (cap0) rdata0_q <= c_rdata;
         if (cap1) rdata1_q <= c_rdata;
      end
   end

   // Bus-side and master-side outputs decoded from the registered state, so
   // an asynchronous reset clears them (including c_we) immediately.
   always_comb begin
      c_address = '0;
      c_wdata   = '0;
      c_we      = 1'b0;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      if (state_q == BUSY) begin
         c_address = addr_q;
         c_wdata   = wdata_q;
         c_we      = we_q && (cnt_q == '0);
      end
      if (state_q == DONE) begin
         m0_ack = (gnt_q == MASTER_CPU);
         m1_ack = (gnt_q == MASTER_DMA);
      end
   end

   assign bus_busy = (state_q == BUSY) || (state_q == DONE);
   assign gnt_id   = gnt_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Three instances with WAIT_CYCLES = 1, 2, 3
// share one clock; each step drives inputs 1 time unit after a rising edge
// and checks outputs at that same point, away from the next active edge.
module tb_bus_arbiter;

   logic        clk;
   logic        rst      [3];
   logic        m0_req   [3];
   logic        m0_we    [3];
   logic [31:0] m0_addr  [3];
   logic [31:0] m0_wdata [3];
   logic        m0_ack   [3];
   logic [31:0] m0_rdata [3];
   logic        m1_req   [3];
   logic        m1_we    [3];
   logic [31:0] m1_addr  [3];
   logic [31:0] m1_wdata [3];
   logic        m1_ack   [3];
   logic [31:0] m1_rdata [3];
   logic [31:0] c_address[3];
   logic        c_we     [3];
   logic [31:0] c_wdata  [3];
   logic [31:0] c_rdata  [3];
   logic        gnt_id   [3];
   logic        bus_busy [3];

   int tests  = 0;
   int failed = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bus_arbiter #(.WAIT_CYCLES(g + 1), .AW(32), .DW(32)) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .m0_req    (m0_req[g]),
         .m0_we     (m0_we[g]),
         .m0_addr   (m0_addr[g]),
         .m0_wdata  (m0_wdata[g]),
         .m0_ack    (m0_ack[g]),
         .m0_rdata  (m0_rdata[g]),
         .m1_req    (m1_req[g]),
         .m1_we     (m1_we[g]),
         .m1_addr   (m1_addr[g]),
         .m1_wdata  (m1_wdata[g]),
         .m1_ack    (m1_ack[g]),
         .m1_rdata  (m1_rdata[g]),
         .c_address (c_address[g]),
         .c_we      (c_we[g]),
         .c_wdata   (c_wdata[g]),
         .c_rdata   (c_rdata[g]),
         .gnt_id    (gnt_id[g]),
         .bus_busy  (bus_busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic order[8];
   logic gids [8];
   int   n_ack;

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1;
         m0_req[i] = 1'b0; m0_we[i] = 1'b0; m0_addr[i] = '0; m0_wdata[i] = '0;
         m1_req[i] = 1'b0; m1_we[i] = 1'b0; m1_addr[i] = '0; m1_wdata[i] = '0;
         c_rdata[i] = '0;
      end
      tick();
      tick();

      // Reset state of every instance.
      for (int i = 0; i < 3; i++) begin
         check("rst_c_address", c_address[i], 32'h0);
         check("rst_c_we",      32'(c_we[i]), 32'h0);
         check("rst_c_wdata",   c_wdata[i], 32'h0);
         check("rst_bus_busy",  32'(bus_busy[i]), 32'h0);
         check("rst_gnt_id",    32'(gnt_id[i]), 32'h0);
         check("rst_acks",      32'({m1_ack[i], m0_ack[i]}), 32'h0);
         check("rst_m0_rdata",  m0_rdata[i], 32'h0);
         check("rst_m1_rdata",  m1_rdata[i], 32'h0);
      end
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      tick();

      // Contention after reset on W=1: both reqs held, grants must alternate m0,m1,m0,m1.
      m0_addr[0] = 32'h0000_0100; m1_addr[0] = 32'h0000_0200; c_rdata[0] = 32'h0000_0011;
      m0_req[0] = 1'b1; m1_req[0] = 1'b1;
      n_ack = 0;
      for (int c = 0; c < 11; c++) begin
         tick();
         check("cont_no_overlap", 32'(m0_ack[0] & m1_ack[0]), 32'h0);
         if ((m0_ack[0] | m1_ack[0]) && n_ack < 8) begin
            order[n_ack] = m1_ack[0];
            gids[n_ack]  = gnt_id[0];
            n_ack++;
         end
      end
      m0_req[0] = 1'b0; m1_req[0] = 1'b0;
      check("cont_ack_count", 32'(n_ack), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check("cont_order",  32'(order[k]), 32'(k % 2));
         check("cont_gnt_id", 32'(gids[k]),  32'(k % 2));
      end
      tick();

      // Single read on W=1: ack two edges after req is driven, rdata held afterwards.
      m0_addr[0] = 32'h0000_1004; m0_we[0] = 1'b0; c_rdata[0] = 32'hDEAD_BEEF;
      m0_req[0] = 1'b1;
      tick();
      check("rd_c_address", c_address[0], 32'h0000_1004);
      check("rd_busy",      32'(bus_busy[0]), 32'h1);
      check("rd_gnt_id",    32'(gnt_id[0]), 32'h0);
      check("rd_no_ack_yet", 32'(m0_ack[0]), 32'h0);
      tick();
      check("rd_ack",        32'(m0_ack[0]), 32'h1);
      check("rd_rdata",      m0_rdata[0], 32'hDEAD_BEEF);
      check("rd_addr_clear", c_address[0], 32'h0);
      m0_req[0] = 1'b0; c_rdata[0] = 32'h0;
      tick();
      check("rd_ack_one_cycle", 32'(m0_ack[0]), 32'h0);
      tick();
      check("rd_rdata_held", m0_rdata[0], 32'hDEAD_BEEF);

      // Write strobe on W=3: address stable 3 cycles, c_we only in the third.
      m1_we[2] = 1'b1; m1_addr[2] = 32'h0000_0104; m1_wdata[2] = 32'h0000_00A5;
      c_rdata[2] = 32'hFFFF_FFFF;
      m1_req[2] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("wr_c_address", c_address[2], 32'h0000_0104);
         check("wr_c_wdata",   c_wdata[2], 32'h0000_00A5);
         check("wr_c_we",      32'(c_we[2]), (k == 3) ? 32'h1 : 32'h0);
         check("wr_no_ack",    32'(m1_ack[2]), 32'h0);
      end
      tick();
      check("wr_ack",        32'(m1_ack[2]), 32'h1);
      check("wr_rdata_kept", m1_rdata[2], 32'h0);
      check("wr_c_we_off",   32'(c_we[2]), 32'h0);
      m1_req[2] = 1'b0; m1_we[2] = 1'b0;
      tick();

      // Late address change on W=3 during BUSY is ignored.
      m0_we[2] = 1'b0; m0_addr[2] = 32'h0000_1000; c_rdata[2] = 32'hCAFE_0001;
      m0_req[2] = 1'b1;
      tick();
      check("late_c_address", c_address[2], 32'h0000_1000);
      m0_addr[2] = 32'h0000_2000;
      tick();
      check("late_c_address", c_address[2], 32'h0000_1000);
      tick();
      check("late_c_address", c_address[2], 32'h0000_1000);
      tick();
      check("late_ack",   32'(m0_ack[2]), 32'h1);
      check("late_rdata", m0_rdata[2], 32'hCAFE_0001);
      m0_req[2] = 1'b0;
      tick();

      // Reset in the strobe cycle of a W=2 write.
      m0_we[1] = 1'b1; m0_addr[1] = 32'h0000_0200; m0_wdata[1] = 32'h0000_0055;
      m0_req[1] = 1'b1;
      tick();
      check("rw_pre_c_we", 32'(c_we[1]), 32'h0);
      tick();
      check("rw_strobe",   32'(c_we[1]), 32'h1);
      rst[1] = 1'b1;
      #1;
      check("rw_c_we_async", 32'(c_we[1]), 32'h0);
      check("rw_c_address",  c_address[1], 32'h0);
      check("rw_c_wdata",    c_wdata[1], 32'h0);
      check("rw_bus_busy",   32'(bus_busy[1]), 32'h0);
      check("rw_gnt_id",     32'(gnt_id[1]), 32'h0);
      m0_req[1] = 1'b0; m0_we[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rw_no_ack", 32'({m1_ack[1], m0_ack[1]}), 32'h0);
      end
      rst[1] = 1'b0;
      m1_we[1] = 1'b0; m1_addr[1] = 32'h0000_0300; c_rdata[1] = 32'h1234_5678;
      m1_req[1] = 1'b1;
      tick();
      check("post_rst_c_address", c_address[1], 32'h0000_0300);
      check("post_rst_gnt_id",    32'(gnt_id[1]), 32'h1);
      tick();
      check("post_rst_no_ack", 32'(m1_ack[1]), 32'h0);
      tick();
      check("post_rst_ack",   32'(m1_ack[1]), 32'h1);
      check("post_rst_rdata", m1_rdata[1], 32'h1234_5678);
      check("post_rst_m0_rdata", m0_rdata[1], 32'h0);
      m1_req[1] = 1'b0;
      tick();

      // Idle bus for 10 cycles on W=2.
      for (int k = 0; k < 10; k++) begin
         tick();
         check("idle_c_address", c_address[1], 32'h0);
         check("idle_c_we",      32'(c_we[1]), 32'h0);
         check("idle_c_wdata",   c_wdata[1], 32'h0);
         check("idle_bus_busy",  32'(bus_busy[1]), 32'h0);
         check("idle_acks",      32'({m1_ack[1], m0_ack[1]}), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
